// File: rtl/hdmi_rgb_to_ycbcr422.sv
// RGB888 to BT.601 limited-range YCbCr 4:2:2 converter for the HDMI transmitter pins.
// Define HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN for averaged chroma (adds one lookahead stage).
module hdmi_rgb_to_ycbcr422 #(
    parameter bit         CB_FIRST = 1'b1,
    parameter logic [7:0] BLANK_Y  = 8'h10,
    parameter logic [7:0] BLANK_C  = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_data_e,
    input  logic [23:0] in_data,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_data_e,
    output logic [15:0] out_data
);

    function automatic logic signed [17:0] mul(input logic [7:0] c, input logic signed [8:0] k);
        return $signed({10'd0, c}) * k;
    endfunction

    // Round, shift, offset and clamp a coefficient sum into an 8-bit code.
    function automatic logic [7:0] scale_clamp(input logic signed [17:0] sum,
                                               input logic signed [17:0] offset,
                                               input logic signed [17:0] hi);
        logic signed [17:0] v;
        v = ((sum + 18'sd128) >>> 8) + offset;
        if (v < 18'sd16) v = 18'sd16;
        else if (v > hi) v = hi;
        return v[7:0];
    endfunction

`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
    function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction
`endif

    logic                phase_q, phase_d;
    logic signed [17:0]  prod_p1_q [9];
    logic signed [17:0]  prod_p1_d [9];
    logic                hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, de_p1_q, de_p1_d, ph_p1_q, ph_p1_d;
    logic [7:0]          y_p2_q, y_p2_d, cb_p2_q, cb_p2_d, cr_p2_q, cr_p2_d;
    logic                hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d, de_p2_q, de_p2_d, ph_p2_q, ph_p2_d;
`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
    logic [7:0]          y_p3_q, y_p3_d, cb_p3_q, cb_p3_d, cr_p3_q, cr_p3_d;
    logic                hs_p3_q, hs_p3_d, vs_p3_q, vs_p3_d, de_p3_q, de_p3_d, ph_p3_q, ph_p3_d;
`endif
    logic [7:0]          held_q, held_d;
    logic                out_hsync_q, out_hsync_d, out_vsync_q, out_vsync_d;
    logic                out_data_e_q, out_data_e_d;
    logic [15:0]         out_data_q, out_data_d;

    logic [7:0] cur_y, cur_cb, cur_cr, first_c, second_c, c_sel;
    logic       cur_hs, cur_vs, cur_de, cur_ph;

    always_comb begin
        // Stage 1: pair phase and the nine component products
        phase_d = in_data_e ? ~phase_q : 1'b0;
        ph_p1_d = in_data_e ? phase_q : 1'b0;
        hs_p1_d = in_hsync;
        vs_p1_d = in_vsync;
        de_p1_d = in_data_e;
        prod_p1_d[0] = mul(in_data[23:16], 9'sd66);
        prod_p1_d[1] = mul(in_data[15:8],  9'sd129);
        prod_p1_d[2] = mul(in_data[7:0],   9'sd25);
        prod_p1_d[3] = mul(in_data[23:16], -9'sd38);
        prod_p1_d[4] = mul(in_data[15:8],  -9'sd74);
        prod_p1_d[5] = mul(in_data[7:0],   9'sd112);
        prod_p1_d[6] = mul(in_data[23:16], 9'sd112);
        prod_p1_d[7] = mul(in_data[15:8],  -9'sd94);
        prod_p1_d[8] = mul(in_data[7:0],   -9'sd18);

        // Stage 2: sum, scale and clamp
        y_p2_d  = scale_clamp(prod_p1_q[0] + prod_p1_q[1] + prod_p1_q[2], 18'sd16,  18'sd235);
        cb_p2_d = scale_clamp(prod_p1_q[3] + prod_p1_q[4] + prod_p1_q[5], 18'sd128, 18'sd240);
        cr_p2_d = scale_clamp(prod_p1_q[6] + prod_p1_q[7] + prod_p1_q[8], 18'sd128, 18'sd240);
        hs_p2_d = hs_p1_q;
        vs_p2_d = vs_p1_q;
        de_p2_d = de_p1_q;
        ph_p2_d = ph_p1_q;

`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
        // Stage 3: lookahead register so an even pixel can see its odd partner
        y_p3_d  = y_p2_q;
        cb_p3_d = cb_p2_q;
        cr_p3_d = cr_p2_q;
        hs_p3_d = hs_p2_q;
        vs_p3_d = vs_p2_q;
        de_p3_d = de_p2_q;
        ph_p3_d = ph_p2_q;
        cur_y = y_p3_q;  cur_cb = cb_p3_q;  cur_cr = cr_p3_q;
        cur_hs = hs_p3_q; cur_vs = vs_p3_q; cur_de = de_p3_q; cur_ph = ph_p3_q;
`else
        cur_y = y_p2_q;  cur_cb = cb_p2_q;  cur_cr = cr_p2_q;
        cur_hs = hs_p2_q; cur_vs = vs_p2_q; cur_de = de_p2_q; cur_ph = ph_p2_q;
`endif

        // Output stage: chroma select and blanking
        first_c  = CB_FIRST ? cur_cb : cur_cr;
        second_c = CB_FIRST ? cur_cr : cur_cb;
        held_d   = held_q;
        c_sel    = BLANK_C;
        if (cur_de) begin
            if (!cur_ph) begin
                held_d = second_c;
                c_sel  = first_c;
`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
                if (de_p2_q && ph_p2_q)
                    c_sel = avg(first_c, CB_FIRST ? cb_p2_q : cr_p2_q);
`endif
            end else begin
`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
                c_sel = avg(held_q, second_c);
`else
                c_sel = held_q;
`endif
            end
        end
        out_data_d   = cur_de ? {cur_y, c_sel} : {BLANK_Y, BLANK_C};
        out_hsync_d  = cur_hs;
        out_vsync_d  = cur_vs;
        out_data_e_d = cur_de;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            for (int i = 0; i < 9; i++) prod_p1_q[i] <= '0;
            hs_p1_q <= 1'b0; vs_p1_q <= 1'b0; de_p1_q <= 1'b0; ph_p1_q <= 1'b0;
            y_p2_q  <= '0;   cb_p2_q <= '0;   cr_p2_q <= '0;
            hs_p2_q <= 1'b0; vs_p2_q <= 1'b0; de_p2_q <= 1'b0; ph_p2_q <= 1'b0;
`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
            y_p3_q  <= '0;   cb_p3_q <= '0;   cr_p3_q <= '0;
            hs_p3_q <= 1'b0; vs_p3_q <= 1'b0; de_p3_q <= 1'b0; ph_p3_q <= 1'b0;
`endif
            held_q       <= 8'h80;
            out_hsync_q  <= 1'b0;
            out_vsync_q  <= 1'b0;
            out_data_e_q <= 1'b0;
            out_data_q   <= 16'h1080;
        end else begin
            phase_q <= phase_d;
            for (int i = 0; i < 9; i++) prod_p1_q[i] <= prod_p1_d[i];
            hs_p1_q <= hs_p1_d; vs_p1_q <= vs_p1_d; de_p1_q <= de_p1_d; ph_p1_q <= ph_p1_d;
            y_p2_q  <= y_p2_d;  cb_p2_q <= cb_p2_d; cr_p2_q <= cr_p2_d;
            hs_p2_q <= hs_p2_d; vs_p2_q <= vs_p2_d; de_p2_q <= de_p2_d; ph_p2_q <= ph_p2_d;
`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
            y_p3_q  <= y_p3_d;  cb_p3_q <= cb_p3_d; cr_p3_q <= cr_p3_d;
            hs_p3_q <= hs_p3_d; vs_p3_q <= vs_p3_d; de_p3_q <= de_p3_d; ph_p3_q <= ph_p3_d;
`endif
            held_q       <= held_d;
            out_hsync_q  <= out_hsync_d;
            out_vsync_q  <= out_vsync_d;
            out_data_e_q <= out_data_e_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_hsync  = out_hsync_q;
    assign out_vsync  = out_vsync_q;
    assign out_data_e = out_data_e_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_hdmi_rgb_to_ycbcr422.sv
// Directed-vector bench for hdmi_rgb_to_ycbcr422 (default and CB_FIRST=0 instances).
module tb_hdmi_rgb_to_ycbcr422;

`ifdef HDMI_RGB_TO_YCBCR422_CHROMA_AVG_EN
    localparam int LAT = 4;
    localparam logic [15:0] RED_EXP  = 16'h52A5;
    localparam logic [15:0] BLUE_EXP = 16'h29AF;
`else
    localparam int LAT = 3;
    localparam logic [15:0] RED_EXP  = 16'h525A;
    localparam logic [15:0] BLUE_EXP = 16'h29F0;
`endif
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_hsync, in_vsync, in_data_e;
    logic [23:0] in_data;
    logic        out_hsync, out_vsync, out_data_e;
    logic [15:0] out_data;
    logic        b_hsync, b_vsync, b_data_e;
    logic [15:0] b_data;

    hdmi_rgb_to_ycbcr422 dut (
        .clk(clk), .reset(reset), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_data_e(in_data_e), .in_data(in_data), .out_hsync(out_hsync),
        .out_vsync(out_vsync), .out_data_e(out_data_e), .out_data(out_data));

    hdmi_rgb_to_ycbcr422 #(.CB_FIRST(1'b0)) dut_cr (
        .clk(clk), .reset(reset), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_data_e(in_data_e), .in_data(in_data), .out_hsync(b_hsync),
        .out_vsync(b_vsync), .out_data_e(b_data_e), .out_data(b_data));

    int checks = 0;
    int failures = 0;

    logic [23:0] s_data [32];
    logic        s_de [32], s_hs [32], s_vs [32];
    logic [15:0] e_data [32];
    logic [15:0] o_data [40], o_bdata [40];
    logic        o_de [40], o_hs [40], o_vs [40];

    task automatic set_stim(input int k, input logic hs, input logic vs, input logic de,
                            input logic [23:0] d, input logic [15:0] exp_d);
        s_hs[k] = hs; s_vs[k] = vs; s_de[k] = de; s_data[k] = d; e_data[k] = exp_d;
    endtask

    // Drive n stimulus cycles followed by idle cycles, capturing outputs #1 after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n + LAT; i++) begin
            if (i < n) begin
                in_hsync = s_hs[i]; in_vsync = s_vs[i]; in_data_e = s_de[i]; in_data = s_data[i];
            end else begin
                in_hsync = 1'b0; in_vsync = 1'b0; in_data_e = 1'b0; in_data = 24'h0;
            end
            @(posedge clk); #1;
            o_data[i] = out_data; o_bdata[i] = b_data;
            o_de[i] = out_data_e; o_hs[i] = out_hsync; o_vs[i] = out_vsync;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_hsync = 1'($urandom); in_vsync = 1'($urandom);
            in_data_e = 1'($urandom); in_data = 24'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (out_hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync got %b want 0", out_hsync); end
        checks++; if (out_vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync got %b want 0", out_vsync); end
        checks++; if (out_data_e !== 1'b0) begin failures++; $display("FAIL reset_de got %b want 0", out_data_e); end
        checks++; if (out_data !== 16'h1080) begin failures++; $display("FAIL reset_data got %h want 1080", out_data); end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) set_stim(k, 1'b1, 1'b1, 1'b1, WHITE, 16'hEB80);
        run(5);
        for (int j = 0; j < LAT - 1; j++) begin
            checks++;
            if (o_data[j] !== 16'h1080 || o_de[j] !== 1'b0 || o_hs[j] !== 1'b0) begin
                failures++;
                $display("FAIL release_hold[%0d] got data=%h de=%b hs=%b want 1080/0/0", j, o_data[j], o_de[j], o_hs[j]);
            end
        end
        checks++;
        if (o_data[LAT-1] !== 16'hEB80 || o_de[LAT-1] !== 1'b1 || o_hs[LAT-1] !== 1'b1) begin
            failures++;
            $display("FAIL release_track got data=%h de=%b hs=%b want eb80/1/1", o_data[LAT-1], o_de[LAT-1], o_hs[LAT-1]);
        end
    endtask

    task automatic test_black_white();
        set_stim(0, 1'b0, 1'b0, 1'b1, 24'h000000, 16'h1080);
        set_stim(1, 1'b0, 1'b0, 1'b1, 24'h000000, 16'h1080);
        set_stim(2, 1'b0, 1'b0, 1'b1, WHITE, 16'hEB80);
        set_stim(3, 1'b0, 1'b0, 1'b1, WHITE, 16'hEB80);
        run(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_data[k+LAT-1] !== e_data[k]) begin
                failures++; $display("FAIL black_white[%0d] got %h want %h", k, o_data[k+LAT-1], e_data[k]);
            end
        end
    endtask

    task automatic test_red_blue();
        for (int k = 0; k < 6; k++)
            set_stim(k, 1'b0, 1'b0, 1'b1, k[0] ? BLUE : RED, k[0] ? BLUE_EXP : RED_EXP);
        run(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (o_data[k+LAT-1] !== e_data[k]) begin
                failures++; $display("FAIL red_blue[%0d] got %h want %h", k, o_data[k+LAT-1], e_data[k]);
            end
        end
    endtask

    task automatic test_sync_line();
        set_stim(0, 1'b1, 1'b1, 1'b0, 24'h123456, 16'h1080);
        set_stim(1, 1'b1, 1'b1, 1'b0, 24'h123456, 16'h1080);
        set_stim(2, 1'b0, 1'b0, 1'b0, WHITE, 16'h1080);
        for (int p = 0; p < 7; p++)
            set_stim(3 + p, 1'b0, 1'b0, 1'b1, p[0] ? BLUE : RED, p[0] ? BLUE_EXP : RED_EXP);
        set_stim(9, 1'b0, 1'b0, 1'b1, RED, 16'h525A);
        set_stim(10, 1'b1, 1'b0, 1'b0, RED, 16'h1080);
        set_stim(11, 1'b0, 1'b0, 1'b0, BLUE, 16'h1080);
        set_stim(12, 1'b0, 1'b0, 1'b1, RED, RED_EXP);
        set_stim(13, 1'b0, 1'b0, 1'b1, BLUE, BLUE_EXP);
        run(14);
        checks++;
        if (o_hs[LAT-2] !== 1'b0 || o_vs[LAT-2] !== 1'b0) begin
            failures++; $display("FAIL sync_early got hs=%b vs=%b want 0/0", o_hs[LAT-2], o_vs[LAT-2]);
        end
        for (int k = 0; k < 14; k++) begin
            checks++;
            if (o_data[k+LAT-1] !== e_data[k] || o_de[k+LAT-1] !== s_de[k] ||
                o_hs[k+LAT-1] !== s_hs[k] || o_vs[k+LAT-1] !== s_vs[k]) begin
                failures++;
                $display("FAIL sync_line[%0d] got data=%h de=%b hs=%b vs=%b want %h/%b/%b/%b", k,
                         o_data[k+LAT-1], o_de[k+LAT-1], o_hs[k+LAT-1], o_vs[k+LAT-1],
                         e_data[k], s_de[k], s_hs[k], s_vs[k]);
            end
        end
    endtask

    task automatic test_cb_first0();
        set_stim(0, 1'b0, 1'b0, 1'b1, BLUE, 16'h296E);
        set_stim(1, 1'b0, 1'b0, 1'b1, BLUE, 16'h29F0);
        run(2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_bdata[k+LAT-1] !== e_data[k]) begin
                failures++; $display("FAIL cb_first0[%0d] got %h want %h", k, o_bdata[k+LAT-1], e_data[k]);
            end
        end
    endtask

    task automatic test_mid_pair_drop();
        set_stim(0, 1'b0, 1'b0, 1'b1, BLUE, 16'h29F0);
        set_stim(1, 1'b0, 1'b0, 1'b0, BLUE, 16'h1080);
        set_stim(2, 1'b0, 1'b0, 1'b1, RED, 16'h525A);
        set_stim(3, 1'b0, 1'b0, 1'b0, RED, 16'h1080);
        run(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_data[k+LAT-1] !== e_data[k]) begin
                failures++; $display("FAIL de_drop[%0d] got %h want %h", k, o_data[k+LAT-1], e_data[k]);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        in_hsync = 1'b0; in_vsync = 1'b0; in_data_e = 1'b1; in_data = RED;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_stim(0, 1'b0, 1'b0, 1'b1, BLUE, 16'h29F0);
        set_stim(1, 1'b0, 1'b0, 1'b0, BLUE, 16'h1080);
        run(2);
        checks++;
        if (o_data[LAT-2] !== 16'h1080 || o_de[LAT-2] !== 1'b0) begin
            failures++; $display("FAIL reset_mid_flush got %h/%b want 1080/0", o_data[LAT-2], o_de[LAT-2]);
        end
        checks++;
        if (o_data[LAT-1] !== 16'h29F0) begin
            failures++; $display("FAIL reset_mid_even got %h want 29f0", o_data[LAT-1]);
        end
    endtask

    initial begin
        reset = 1'b1; in_hsync = 1'b0; in_vsync = 1'b0; in_data_e = 1'b0; in_data = 24'h0;
        test_reset();
        test_black_white();
        test_red_blue();
        test_sync_line();
        test_cb_first0();
        test_mid_pair_drop();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
